// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges per-stage stall requests into a contiguous stall vector,
// times stall episodes, raises a sticky watchdog flag and pulses stall_release after each one.
// Optional per-source perf counters are enabled with `define PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             wdt_clr,
    output logic [5:0]       stall,
    output logic             stall_release,
    output logic [CNT_W-1:0] stall_len,
    output logic             wdt_hung,
    input  logic [1:0]       perf_sel,
    output logic [CNT_W-1:0] perf_rdata
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_HUNG  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TRIP_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cur_cnt;
    logic             any_req;
    logic             trip;

    assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

    // Deepest requester wins; WB (bit5) is never stopped.
    always_comb begin
        stall = 6'b000000;
        if (!rst) begin
            if (stallreq_mem)
                stall = 6'b011111;
            else if (stallreq_ex)
                stall = 6'b001111;
            else if (stallreq_id)
                stall = 6'b000111;
            else if (stallreq_if)
                stall = 6'b000011;
        end
    end

    assign trip = any_req && (state == ST_STALL) && (cur_cnt == TRIP_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            cur_cnt       <= '0;
            stall_len     <= '0;
            stall_release <= 1'b0;
            wdt_hung      <= 1'b0;
        end else begin
            stall_release <= 1'b0;
            if (any_req) begin
                case (state)
                    ST_RUN: begin
                        state   <= ST_STALL;
                        cur_cnt <= CNT_ONE;
                    end
                    default: begin
                        if (trip)
                            state <= ST_HUNG;
                        if (cur_cnt != CNT_MAX)
                            cur_cnt <= cur_cnt + CNT_ONE;
                    end
                endcase
            end else if (state != ST_RUN) begin
                state         <= ST_RUN;
                stall_len     <= cur_cnt;
                stall_release <= 1'b1;
                cur_cnt       <= '0;
            end

            // A trip on the same edge as a clear keeps the flag set.
            if (trip)
                wdt_hung <= 1'b1;
            else if (wdt_clr)
                wdt_hung <= 1'b0;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic [CNT_W-1:0] perf_cnt [4];
    logic [1:0]       win_sel;

    always_comb begin
        win_sel = 2'd0;
        if (stallreq_mem)
            win_sel = 2'd3;
        else if (stallreq_ex)
            win_sel = 2'd2;
        else if (stallreq_id)
            win_sel = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                perf_cnt[i] <= '0;
            perf_rdata <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (any_req && (win_sel == 2'(i)) && (perf_cnt[i] != CNT_MAX))
                    perf_cnt[i] <= perf_cnt[i] + CNT_ONE;
            end
            perf_rdata <= perf_cnt[perf_sel];
        end
    end
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel;
    assign perf_rdata      = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl with an 8-cycle watchdog timeout.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        wdt_clr;
    logic [5:0]  stall;
    logic        stall_release;
    logic [31:0] stall_len;
    logic        wdt_hung;
    logic [1:0]  perf_sel;
    logic [31:0] perf_rdata;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

`ifdef PIPE_STALL_PERF_EN
    localparam logic [31:0] EXP_PERF_EX = 32'd4;
    localparam logic [31:0] EXP_PERF_IF = 32'd2;
`else
    localparam logic [31:0] EXP_PERF_EX = 32'd0;
    localparam logic [31:0] EXP_PERF_IF = 32'd0;
`endif

    pipe_stall_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .wdt_clr       (wdt_clr),
        .stall         (stall),
        .stall_release (stall_release),
        .stall_len     (stall_len),
        .wdt_hung      (wdt_hung),
        .perf_sel      (perf_sel),
        .perf_rdata    (perf_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
        stallreq_if  = r_if;
        stallreq_id  = r_id;
        stallreq_ex  = r_ex;
        stallreq_mem = r_mem;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wdt_clr = 1'b0; perf_sel = 2'd0;
        drv(0, 1, 0, 0);
        mid(); chk("stall_in_rst", 32'(stall), 32'h00); tick();
        drv(0, 0, 0, 0);
        mid(); tick();
        rst = 1'b0;
        mid();
        chk("rst_stall", 32'(stall), 32'h00);
        chk("rst_release", 32'(stall_release), 32'd0);
        chk("rst_len", stall_len, 32'd0);
        chk("rst_hung", 32'(wdt_hung), 32'd0);
        chk("rst_perf", perf_rdata, 32'd0);
        tick();

        // mem stall aborted by reset: no release, length not recorded
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 0, 1); mid(); chk("mem_stall", 32'(stall), 32'h1f); tick();
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mid(); chk("mem_stall_rst", 32'(stall), 32'h00); tick();
        end
        rst = 1'b0; drv(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("abort_release", 32'(stall_release), 32'd0);
            chk("abort_len", stall_len, 32'd0);
            tick();
        end

        // id for 3 cycles
        for (int k = 0; k < 3; k++) begin
            drv(0, 1, 0, 0); mid(); chk("id_stall", 32'(stall), 32'h07); tick();
        end
        drv(0, 0, 0, 0);
        mid(); chk("id_stall_off", 32'(stall), 32'h00); chk("id_rel_early", 32'(stall_release), 32'd0); tick();
        mid(); chk("id_release", 32'(stall_release), 32'd1); chk("id_len", stall_len, 32'd3); tick();
        mid(); chk("id_rel_once", 32'(stall_release), 32'd0); tick();

        // id and mem together
        drv(0, 1, 0, 1); mid(); chk("id_mem_stall", 32'(stall), 32'h1f); tick();
        drv(0, 0, 0, 0); mid(); tick();
        mid(); chk("id_mem_release", 32'(stall_release), 32'd1); chk("id_mem_len", stall_len, 32'd1); tick();

        // id,id,ex,ex as one episode
        drv(0, 1, 0, 0); mid(); chk("mix_s0", 32'(stall), 32'h07); tick();
        mid(); chk("mix_s1", 32'(stall), 32'h07); tick();
        drv(0, 0, 1, 0); mid(); chk("mix_s2", 32'(stall), 32'h0f); chk("mix_no_rel", 32'(stall_release), 32'd0); tick();
        mid(); chk("mix_s3", 32'(stall), 32'h0f); chk("mix_no_rel2", 32'(stall_release), 32'd0); tick();
        drv(0, 0, 0, 0); mid(); tick();
        mid(); chk("mix_release", 32'(stall_release), 32'd1); chk("mix_len", stall_len, 32'd4); tick();
        mid(); chk("mix_rel_once", 32'(stall_release), 32'd0); tick();

        // if for 2 cycles, then a new request on the release cycle
        for (int k = 0; k < 2; k++) begin
            drv(1, 0, 0, 0); mid(); chk("if_stall", 32'(stall), 32'h03); tick();
        end
        drv(0, 0, 0, 0); mid(); tick();
        drv(1, 0, 0, 0); mid();
        chk("reassert_rel", 32'(stall_release), 32'd1);
        chk("reassert_stall", 32'(stall), 32'h03);
        chk("reassert_len", stall_len, 32'd2);
        tick();
        drv(0, 0, 0, 0); mid(); chk("reassert_rel_low", 32'(stall_release), 32'd0); tick();
        mid(); chk("reassert_rel2", 32'(stall_release), 32'd1); chk("reassert_len2", stall_len, 32'd1); tick();

        // watchdog: ex held for 10 cycles
        for (int k = 1; k <= 10; k++) begin
            drv(0, 0, 1, 0); mid();
            if (k == 8) chk("wdt_before_trip", 32'(wdt_hung), 32'd0);
            if (k == 9) chk("wdt_after_trip", 32'(wdt_hung), 32'd1);
            tick();
        end
        drv(0, 0, 0, 0); mid(); chk("wdt_sticky0", 32'(wdt_hung), 32'd1); tick();
        mid();
        chk("wdt_release", 32'(stall_release), 32'd1);
        chk("wdt_len", stall_len, 32'd10);
        chk("wdt_sticky1", 32'(wdt_hung), 32'd1);
        tick();
        wdt_clr = 1'b1; mid(); chk("wdt_clr_pending", 32'(wdt_hung), 32'd1); tick();
        wdt_clr = 1'b0; mid(); chk("wdt_cleared", 32'(wdt_hung), 32'd0); tick();

        // clear coinciding with the trip edge: set wins
        for (int k = 1; k <= 8; k++) begin
            drv(0, 0, 1, 0); wdt_clr = (k == 8); tick();
        end
        drv(0, 0, 0, 0); wdt_clr = 1'b0;
        mid(); chk("wdt_set_wins", 32'(wdt_hung), 32'd1); tick();
        mid(); chk("wdt_len8", stall_len, 32'd8); tick();
        wdt_clr = 1'b1; tick(); wdt_clr = 1'b0;
        mid(); chk("wdt_cleared2", 32'(wdt_hung), 32'd0); tick();

        // perf counters: ex 4 cycles then if 2 cycles
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 1, 0); tick();
        end
        for (int k = 0; k < 2; k++) begin
            drv(1, 0, 0, 0); tick();
        end
        drv(0, 0, 0, 0); mid(); tick();
        perf_sel = 2'd2;
        mid(); chk("perf_ep_len", stall_len, 32'd6); tick();
        mid(); chk("perf_ex", perf_rdata, EXP_PERF_EX); tick();
        perf_sel = 2'd0;
        mid(); chk("perf_latency", perf_rdata, EXP_PERF_EX); tick();
        mid(); chk("perf_if", perf_rdata, EXP_PERF_IF); tick();
        perf_sel = 2'd3; tick();
        mid(); chk("perf_mem", perf_rdata, 32'd0); tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Producer end of the 6-bit pipeline stall vector consumed by every inter-stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Merges per-stage stall requests into the stall vector, tracks stall episodes, flags a hung pipeline via a watchdog, and emits a release pulse.
- Sits beside the datapath, fed by IF (SRAM busy), ID (load-use), EX (multi-cycle ops) and MEM (bus conflict).

Parameters:
- TIMEOUT_CYCLES, 1024, number of consecutive stalled cycles that trips the watchdog.
- CNT_W, 32, width of the episode-length and performance counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high (rst == `RstEnable)
- stallreq_if  input  1  IF stage cannot advance
- stallreq_id  input  1  ID hazard (load-use)
- stallreq_ex  input  1  EX multi-cycle op busy
- stallreq_mem  input  1  MEM bus not ready
- wdt_clr  input  1  clears sticky watchdog flag
- stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop
- stall_release  output  1  one-cycle pulse on the first non-stalled cycle after an episode
- stall_len  output  CNT_W  length of the most recently completed episode
- wdt_hung  output  1  sticky: an episode reached TIMEOUT_CYCLES
- perf_sel  input  2  perf counter select (0 IF, 1 ID, 2 EX, 3 MEM)
- perf_rdata  output  CNT_W  selected perf counter

Behaviour:
- stall is combinational, same cycle as the requests; the deepest requester wins:
  - mem: 6'b011111
  - ex (no mem): 6'b001111
  - id (no ex or mem): 6'b000111
  - if only: 6'b000011
  - none: 6'b000000
- stall never stops WB (bit5 is always 0). While rst=1, stall=0 regardless of requests.
- The stall vector always forms a contiguous prefix, so the first non-stopped stage downstream of a stopped one inserts a bubble.
- FSM states, registered:
  - RUN: any request -> STALL; cur_cnt loads 1.
  - STALL, requests still present: cur_cnt increments, saturating at all-ones. When cur_cnt reaches TIMEOUT_CYCLES-1 while requests persist -> HUNG, and wdt_hung is set on that edge.
  - STALL or HUNG, no requests: -> RUN; stall_len <= cur_cnt; stall_release = 1 for exactly that next cycle; cur_cnt <= 0.
  - HUNG: same counting as STALL. Leaving is identical to leaving STALL.
- A request that changes source mid-episode (e.g. id then ex) continues the same episode; no release pulse.
- A request re-asserted on the cycle right after release starts a new episode. stall_release and the new stall can be high together.
- wdt_hung clears only on rst or wdt_clr. If wdt_clr and the trip edge coincide, set wins.
- Reset values: FSM RUN, cur_cnt 0, stall_len 0, stall_release 0, wdt_hung 0, perf counters 0.
- Reset asserted mid-episode aborts it. stall_len is not updated and no release pulse is given.
- Latency: stall 0 cycles; stall_release and stall_len 1 cycle after the requests drop.

Optional Feature:
- Macro PIPE_STALL_PERF_EN.
- Defined: four CNT_W counters, one per source, saturating at all-ones.
  - A counter increments each cycle its source is the winning (deepest) requester.
  - perf_rdata = counter[perf_sel], registered, 1-cycle read latency.
- Undefined: no counters; perf_rdata tied to 0.

Test Plan:
- stallreq_id=1 for 3 cycles -> stall=6'b000111 those 3 cycles; then stall_release=1 for one cycle and stall_len=3.
- stallreq_id=1 and stallreq_mem=1 in the same cycle -> stall=6'b011111; bit5 never 1.
- id 2 cycles then ex 2 cycles back-to-back -> one episode: stall goes 000111,000111,001111,001111; single release; stall_len=4.
- TIMEOUT_CYCLES=8, stallreq_ex held 10 cycles -> wdt_hung rises after the 8th stalled cycle and stays high after release; wdt_clr pulse -> 0.
- rst pulsed during a 5-cycle mem stall -> stall=0 during rst; no stall_release; stall_len unchanged.
- PIPE_STALL_PERF_EN: ex 4 cycles, if 2 cycles -> perf_sel=2 gives 4, perf_sel=0 gives 2, one cycle after the select.
